mem_responder: RTL



---
 rtl/mem_responder.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: multicycle load/store responder holding the word RAM; define MEM_MISALIGN_CHECK_EN to reject misaligned accesses
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memReq,
   input  logic        memWrite,
   input  logic [2:0]  memFunct3,
   input  logic [31:0] memAddr,
   input  logic [31:0] memWData,
   output logic        memReady,
   output logic        memDone,
   output logic [31:0] memRData,
   output logic        memErr
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic wr;
   logic [2:0] f3;
   logic [AW+1:0] addr;
   logic [31:0] wdata, word, ld, wsh;
   logic [7:0] b;
   logic [15:0] h;
   logic [3:0] be;
   logic commit, illegal, mis, err;
   logic unused_addr;
   logic [31:0] ram [DEPTH_WORDS];
   assign unused_addr = ^memAddr[31:AW+2];
   // next state; the access commits on the BUSY edge where the countdown is exhausted
   always_comb begin
      state_nx = state == IDLE ? (memReq ? BUSY : IDLE) : state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
      commit = state == BUSY && cnt == 4'd0;
   end
   // lane selection, extension, byte enables and error classification of the latched access
   always_comb begin
      word = ram[addr[AW+1:2]];
      b = word[{addr[1:0], 3'b000} +: 8];
      h = addr[1] ? word[31:16] : word[15:0];
      illegal = wr ? f3 > 3'd2 : (f3[1:0] == 2'b11 || f3 == 3'b110);
`ifdef MEM_MISALIGN_CHECK_EN
      mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      err = illegal || mis;
      ld = f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b} : f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : word;
      wsh = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} : f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
      be = f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] : f3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end
   // state register, request latch, countdown and registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         memReady <= 1'b1;
         memDone <= 1'b0;
         memErr <= 1'b0;
         memRData <= '0;
      end else begin
         state <= state_nx;
         memReady <= state_nx == IDLE;
         memDone <= state_nx == DONE;
         if (state == IDLE && memReq) begin
            wr <= memWrite;
            f3 <= memFunct3;
            addr <= memAddr[AW+1:0];
            wdata <= memWData;
            cnt <= 4'(LATENCY - 1);
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            memErr <= err;
            memRData <= (wr || err) ? '0 : ld;
         end else if (state == DONE) begin
            memErr <= 1'b0;
         end
      end
   end
   // byte-enabled store commit; a reset on the commit edge aborts the write and contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && commit && wr && !err)
         for (int k = 0; k < 4; k++)
            if (be[k]) ram[addr[AW+1:2]][8*k +: 8] <= wsh[8*k +: 8];
   end
endmodule
